// File: rtl/fetch_buf_ctrl.sv
// fetch_buf_ctrl: instruction-pair fetch buffer between IF and ID with instruction-barrier hold
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1c00_0000
`endif
module fetch_buf_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_inst0,
  input  logic [31:0] if_inst1,
  input  logic [31:0] if_pc,
  input  logic [6:0]  if_exception,
  input  logic [1:0]  if_excp_flag,
  input  logic [1:0]  if_ibar_flag,
  input  logic        id_ready,
  output logic        fifo_valid,
  output logic [31:0] fifo_inst0,
  output logic [31:0] fifo_inst1,
  output logic [31:0] fifo_pc,
  output logic [31:0] fifo_pcAdd,
  output logic [31:0] fifo_pc_next,
  output logic [6:0]  fifo_exception,
  output logic [1:0]  fifo_excp_flag,
  output logic [1:0]  fifo_ibar_flag,
  input  logic        ibar_done,
  output logic        fetch_buf_empty,
  output logic        fetch_buf_full
);
  typedef enum logic [1:0] {RUN, HOLD, WAIT} state_t;
  typedef struct packed {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] pc;
    logic [6:0]  exception;
    logic [1:0]  excp_flag;
    logic [1:0]  ibar_flag;
  } entry_t;
  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);
  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  state_t           r_state, w_state_nxt;
  entry_t           w_head;
  logic             w_push, w_pop, w_empty, w_full;
  assign w_empty         = r_count == '0;
  assign w_full          = r_count == L_FULL;
  assign w_push          = if_valid && if_ready && !flush;
  assign w_pop           = fifo_valid && id_ready && !flush;
  assign if_ready        = !w_full && r_state == RUN;
  assign fifo_valid      = !w_empty;
  assign fetch_buf_empty = w_empty;
  assign fetch_buf_full  = w_full;
  assign fifo_inst0      = w_head.inst0;
  assign fifo_inst1      = w_head.inst1;
  assign fifo_pc         = w_head.pc;
  assign fifo_pcAdd      = w_head.pc + 32'd4;
  assign fifo_pc_next    = w_head.pc + 32'd8;
  assign fifo_exception  = w_head.exception;
  assign fifo_excp_flag  = w_head.excp_flag;
  assign fifo_ibar_flag  = w_head.ibar_flag;
  // head view: stored entry, or a NOP pair at the reset PC while empty
  always_comb begin
    w_head = w_empty ? '{inst0: `INST_NOP, inst1: `INST_NOP, pc: `PC_RESET,
                         exception: '0, excp_flag: '0, ibar_flag: '0}
                     : r_mem[r_head];
  end
  // entry storage, written at tail on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{inst0: if_inst0, inst1: if_inst1, pc: if_pc,
                                   exception: if_exception, excp_flag: if_excp_flag,
                                   ibar_flag: if_ibar_flag};
  end
  // pointers and occupancy; flush discards everything including same-cycle traffic
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                 (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    end
  end
  // barrier FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= RUN;
    else r_state <= w_state_nxt;
  end
  // barrier FSM: stop accepting after a barrier push until it leaves and the backend finishes it
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = flush                                                     ? RUN  :
                  (r_state == RUN && w_push && if_ibar_flag != 2'd0)        ? HOLD :
                  (r_state == HOLD && w_pop && w_head.ibar_flag != 2'd0)    ? WAIT :
                  (r_state == WAIT && ibar_done)                            ? RUN  : r_state;
  end
endmodule

// File: tb/tb_fetch_buf_ctrl.sv
// tb_fetch_buf_ctrl: randomized and directed checks of fetch_buf_ctrl against a queue model
module tb_fetch_buf_ctrl;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam logic [31:0] PCR = 32'h1c00_0000;
  localparam logic [31:0] BASE = 32'h1c00_0000;
  logic clk = 0, rstn = 1, flush = 0, if_valid = 0, id_ready = 0, ibar_done = 0;
  logic [31:0] if_inst0 = 0, if_inst1 = 0, if_pc = 0;
  logic [6:0] if_exception = 0;
  logic [1:0] if_excp_flag = 0, if_ibar_flag = 0;
  logic if_ready, fifo_valid, fetch_buf_empty, fetch_buf_full;
  logic [31:0] fifo_inst0, fifo_inst1, fifo_pc, fifo_pcAdd, fifo_pc_next;
  logic [6:0] fifo_exception;
  logic [1:0] fifo_excp_flag, fifo_ibar_flag;
  int checks = 0, passes = 0, seq = 0, n;
  typedef struct {
    logic [31:0] i0, i1, pc;
    logic [6:0] ex;
    logic [1:0] ef, ib;
  } ent_t;
  ent_t q[$];
  ent_t h, e;
  bit m_bar = 0, m_wait = 0, m_push, m_pop;

  fetch_buf_ctrl #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst0(if_inst0), .if_inst1(if_inst1), .if_pc(if_pc), .if_exception(if_exception),
    .if_excp_flag(if_excp_flag), .if_ibar_flag(if_ibar_flag), .id_ready(id_ready),
    .fifo_valid(fifo_valid), .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1),
    .fifo_pc(fifo_pc), .fifo_pcAdd(fifo_pcAdd), .fifo_pc_next(fifo_pc_next),
    .fifo_exception(fifo_exception), .fifo_excp_flag(fifo_excp_flag),
    .fifo_ibar_flag(fifo_ibar_flag), .ibar_done(ibar_done),
    .fetch_buf_empty(fetch_buf_empty), .fetch_buf_full(fetch_buf_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // reference: a queue of pairs; pushes blocked while a barrier is queued or awaiting completion
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete(); m_bar = 0; m_wait = 0;
    end else if (flush) begin
      q.delete(); m_bar = 0; m_wait = 0;
    end else begin
      m_push = if_valid && q.size() < DEPTH && !m_bar && !m_wait;
      m_pop = q.size() != 0 && id_ready;
      if (m_wait && ibar_done) m_wait = 0;
      if (m_pop) begin
        e = q.pop_front();
        if (e.ib != 0) begin m_bar = 0; m_wait = 1; end
      end
      if (m_push) begin
        q.push_back('{if_inst0, if_inst1, if_pc, if_exception, if_excp_flag, if_ibar_flag});
        if (if_ibar_flag != 0) m_bar = 1;
      end
    end
  end

  // every-cycle comparison of all outputs against the reference
  always @(negedge clk) begin
    if (q.size() != 0) h = q[0];
    else h = '{NOP, NOP, PCR, 7'd0, 2'd0, 2'd0};
    chk("if_ready", 32'(if_ready), 32'(q.size() < DEPTH && !m_bar && !m_wait));
    chk("fifo_valid", 32'(fifo_valid), 32'(q.size() != 0));
    chk("empty", 32'(fetch_buf_empty), 32'(q.size() == 0));
    chk("full", 32'(fetch_buf_full), 32'(q.size() == DEPTH));
    chk("inst0", fifo_inst0, h.i0);
    chk("inst1", fifo_inst1, h.i1);
    chk("pc", fifo_pc, h.pc);
    chk("pcAdd", fifo_pcAdd, h.pc + 32'd4);
    chk("pc_next", fifo_pc_next, h.pc + 32'd8);
    chk("exception", 32'(fifo_exception), 32'(h.ex));
    chk("excp_flag", 32'(fifo_excp_flag), 32'(h.ef));
    chk("ibar_flag", 32'(fifo_ibar_flag), 32'(h.ib));
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    if_valid = 0; id_ready = 0; flush = 0; ibar_done = 0; if_ibar_flag = 0;
  endtask

  task automatic set_pair(input logic [1:0] ib);
    if_inst0 = 32'h1000_0000 + seq; if_inst1 = 32'h2000_0000 + seq;
    if_pc = BASE + 32'(8 * seq); if_exception = 7'(seq); if_excp_flag = 2'(seq);
    if_ibar_flag = ib; seq++;
  endtask

  task automatic push_n(input int k);
    for (int i = 0; i < k; i++) begin set_pair(0); if_valid = 1; tick(); end
    if_valid = 0;
  endtask

  task automatic drain(output int cnt);
    cnt = 0; if_valid = 0; id_ready = 1;
    for (int i = 0; i < 20 && fifo_valid; i++) begin cnt++; tick(); end
    id_ready = 0;
  endtask

  initial begin
    #1 rstn = 0;
    tick(); tick();
    chk("rst_empty", 32'(fetch_buf_empty), 1);
    chk("rst_ready", 32'(if_ready), 1);
    chk("rst_inst0", fifo_inst0, NOP);
    rstn = 1;
    // fill and drain in order
    seq = 0; push_n(8);
    chk("fill_full", 32'(fetch_buf_full), 1);
    chk("fill_ready", 32'(if_ready), 0);
    chk("fill_model", 32'(q.size()), 8);
    id_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", fifo_pc, BASE + 32'(8 * k));
      chk("drain_pcAdd", fifo_pcAdd, BASE + 32'(8 * k + 4));
      tick();
    end
    id_ready = 0;
    chk("drain_empty", 32'(fetch_buf_empty), 1);
    // wraparound
    seq = 0; push_n(5);
    id_ready = 1; tick(); tick(); tick(); id_ready = 0;
    chk("wrap_head", fifo_pc, BASE + 32'd24);
    push_n(6);
    chk("wrap_full", 32'(fetch_buf_full), 1);
    drain(n);
    chk("wrap_drain", 32'(n), 8);
    // simultaneous push and pop
    push_n(3);
    set_pair(0); if_valid = 1; id_ready = 1; tick(); idle();
    chk("simul_model", 32'(q.size()), 3);
    push_n(5);
    chk("simul_full", 32'(fetch_buf_full), 1);
    set_pair(0); if_valid = 1; id_ready = 1; tick(); idle();
    chk("full_pop_nopush", 32'(fetch_buf_full), 0);
    drain(n);
    chk("full_pop_cnt", 32'(n), 7);
    // barrier: HOLD, WAIT, then RUN on ibar_done
    set_pair(1); if_valid = 1; tick(); idle();
    chk("bar_hold", 32'(if_ready), 0);
    id_ready = 1; tick(); id_ready = 0;
    chk("bar_wait", 32'(if_ready), 0);
    tick();
    chk("bar_wait2", 32'(if_ready), 0);
    ibar_done = 1; tick(); ibar_done = 0;
    chk("bar_run", 32'(if_ready), 1);
    // ibar_done already high during the barrier pop still waits one cycle
    set_pair(2); if_valid = 1; tick(); idle();
    id_ready = 1; ibar_done = 1; tick(); id_ready = 0;
    chk("bar_early_wait", 32'(if_ready), 0);
    tick(); ibar_done = 0;
    chk("bar_early_run", 32'(if_ready), 1);
    // flush in HOLD drops the offered pair
    push_n(4);
    set_pair(3); if_valid = 1; tick();
    set_pair(0); tick();
    chk("hold_model", 32'(q.size()), 5);
    flush = 1; set_pair(0); tick(); idle();
    chk("flush_empty", 32'(fetch_buf_empty), 1);
    chk("flush_ready", 32'(if_ready), 1);
    chk("flush_nop", fifo_inst0, NOP);
    tick();
    chk("flush_dropped", 32'(fetch_buf_empty), 1);
    // reset mid-fill, then immediate push after release
    push_n(4);
    #2 rstn = 0; #1;
    chk("rmid_empty", 32'(fetch_buf_empty), 1);
    chk("rmid_valid", 32'(fifo_valid), 0);
    chk("rmid_pc", fifo_pc, PCR);
    rstn = 1; set_pair(0); if_valid = 1; tick(); idle();
    chk("post_rst_push", 32'(fetch_buf_empty), 0);
    chk("post_rst_pc", fifo_pc, BASE + 32'(8 * (seq - 1)));
    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      set_pair(($urandom % 12 == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
      if_inst0 = $urandom; if_inst1 = $urandom; if_pc = $urandom;
      if_exception = 7'($urandom);
      if_valid = ($urandom % 4) != 0;
      id_ready = (c % 200 < 100) ? ($urandom % 3 == 0) : ($urandom % 4 != 0);
      ibar_done = ($urandom % 3) == 0;
      flush = ($urandom % 60) == 0;
      tick();
    end
    idle(); tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
